// File: rtl/serial_add_sub.sv
// -----------------------------------------------------------------------------
// serial_add_sub
//   Bit-serial adder/subtractor. Two WIDTH-bit operands are fed LSB-first
//   through one full-adder cell with a registered carry, one bit per clock.
//   Subtraction is a + ~b + 1: the B operand is inverted on load and the
//   carry is preset to 1.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start_i   request, sampled only in IDLE
//   sub_i     0 = a + b, 1 = a - b (sampled with start_i)
//   a_i, b_i  operands (sampled with start_i)
//   busy_o    high while bits are being processed (state RUN)
//   done_o    one-cycle pulse when s_o/co_o/ovf_o carry a fresh result
//   s_o       sum / difference, modulo 2^WIDTH
//   co_o      carry out; in subtract mode 1 = no borrow (a >= b unsigned)
//   ovf_o     two's-complement signed overflow
// -----------------------------------------------------------------------------
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] s_o,
  output logic             co_o,
  output logic             ovf_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MSB_M1   = CNT_W'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   r_sr_q, r_sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               c_msb_q, c_msb_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               co_q, co_d;
  logic               ovf_q, ovf_d;

  logic fa_s, fa_c;

  // The single full-adder cell.
  assign fa_s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign fa_c = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case leaves it unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    r_sr_d  = r_sr_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_msb_d = c_msb_q;
    s_d     = s_q;
    co_d    = co_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          a_sr_d  = a_i;
          b_sr_d  = sub_i ? ~b_i : b_i;
          carry_d = sub_i;            // the +1 of two's-complement negation
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        r_sr_d  = {fa_s, r_sr_q[WIDTH-1:1]};
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        carry_d = fa_c;
        cnt_d   = cnt_q + CNT_W'(1);

        // Carry into the sign bit; XOR with carry out of it gives overflow.
        if (cnt_q == MSB_M1) begin
          c_msb_d = fa_c;
        end

        if (cnt_q == LAST_BIT) begin
          cnt_d   = cnt_q;            // stop at terminal count, no wrap
          s_d     = {fa_s, r_sr_q[WIDTH-1:1]};
          co_d    = fa_c;
          ovf_d   = c_msb_q ^ fa_c;
          state_d = DONE;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset along with the FSM so that an
  // aborted operation leaves clean zeros on every output, not stale bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      r_sr_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_msb_q <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      r_sr_q  <= r_sr_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_msb_q <= c_msb_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o = (state_q == RUN);
  assign done_o = (state_q == DONE);
  assign s_o    = s_q;
  assign co_o   = co_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// -----------------------------------------------------------------------------
// tb_serial_add_sub
//   Scoreboard bench for serial_add_sub. A WIDTH=8 instance takes directed,
//   handshake, reset and random stimulus; a WIDTH=4 instance is swept over
//   every (a, b, sub). Expected results come from an integer-arithmetic
//   reference model and are queued when a request is accepted; monitors pop
//   and compare whenever done is seen.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_add_sub;

  typedef struct {
    int s;
    bit co;
    bit ovf;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;

  logic       start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, co8, ovf8;
  logic [7:0] s8;

  logic       start4 = 1'b0, sub4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, co4, ovf4;
  logic [3:0] s4;

  exp_t q8[$];
  exp_t q4[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(start8), .sub_i(sub8), .a_i(a8), .b_i(b8),
    .busy_o(busy8), .done_o(done8), .s_o(s8), .co_o(co8), .ovf_o(ovf8)
  );

  serial_add_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_i(start4), .sub_i(sub4), .a_i(a4), .b_i(b4),
    .busy_o(busy4), .done_o(done4), .s_o(s4), .co_o(co4), .ovf_o(ovf4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer add/subtract, unsigned carry/borrow and signed
  // range test.
  function automatic exp_t model(input int w, input int a, input int b, input bit sub);
    exp_t e;
    int mask = (1 << w) - 1;
    int half = 1 << (w - 1);
    int sa   = (a >= half) ? a - (1 << w) : a;
    int sb   = (b >= half) ? b - (1 << w) : b;
    int r, sr;
    if (sub) begin
      r    = a - b;
      sr   = sa - sb;
      e.co = (a >= b);
    end else begin
      r    = a + b;
      sr   = sa + sb;
      e.co = (r > mask);
    end
    e.s   = r & mask;
    e.ovf = (sr >= half) || (sr < -half);
    return e;
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done8: got done with empty scoreboard, expected none (t=%0t)", $time);
      end else begin
        e = q8.pop_front();
        check("s8", s8, e.s);
        check("co8", co8, e.co);
        check("ovf8", ovf8, e.ovf);
      end
    end
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (rst_n && done4) begin
      if (q4.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done4: got done with empty scoreboard, expected none (t=%0t)", $time);
      end else begin
        e = q4.pop_front();
        check("s4", s4, e.s);
        check("co4", co4, e.co);
        check("ovf4", ovf4, e.ovf);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_idle8();
    int n = 0;
    while ((busy8 || done8) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy8 || done8) check("idle_timeout8", 0, 1);
  endtask

  task automatic wait_idle4();
    int n = 0;
    while ((busy4 || done4) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy4 || done4) check("idle_timeout4", 0, 1);
  endtask

  // One WIDTH=8 operation with timing checks. With inject set, start is
  // pulsed with other operands during RUN and again during DONE.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit sub, input bit inject);
    int n = 0;
    int busy_cnt = 0;
    bit hold_ok = 1'b1;
    logic [7:0] s_before;
    @(negedge clk);
    wait_idle8();
    a8 = a; b8 = b; sub8 = sub; start8 = 1'b1;
    s_before = s8;
    @(posedge clk);
    q8.push_back(model(8, a, b, sub));
    #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
    do begin
      @(negedge clk);
      n++;
      if (busy8) busy_cnt++;
      if (!done8 && s8 != s_before) hold_ok = 1'b0;
      if (inject && n == 3) begin
        start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
      end
      if (inject && n == 4) start8 = 1'b0;
    end while (!done8 && n < 40);
    check("latency8", n, 9);
    check("busy_cycles8", busy_cnt, 8);
    check("s_hold8", hold_ok, 1);
    if (inject) start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("done_pulse8", done8, 0);
    check("idle_after_done8", busy8, 0);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input bit sub);
    int n = 0;
    @(negedge clk);
    wait_idle4();
    a4 = a; b4 = b; sub4 = sub; start4 = 1'b1;
    @(posedge clk);
    q4.push_back(model(4, a, b, sub));
    #1;
    start4 = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (!done4 && n < 20);
    if (!done4) check("done_timeout4", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  any;
    int  pushes, dones, last_done, n;

    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_s", s8, 0);
    check("rst_co", co8, 0);
    check("rst_ovf", ovf8, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed add / subtract corner cases.
    op8(8'h05, 8'h03, 1'b0, 1'b0);
    op8(8'h7F, 8'h01, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 1'b0);
    op8(8'h03, 8'h05, 1'b1, 1'b0);
    op8(8'h80, 8'h01, 1'b1, 1'b0);
    op8(8'h00, 8'h00, 1'b1, 1'b0);

    // start pulsed during RUN and DONE must be ignored.
    op8(8'h21, 8'h42, 1'b0, 1'b1);
    any = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy8 || done8) any = 1;
    end
    check("ignored_start8", any, 0);

    // Reset four cycles into RUN, with nonzero outputs from the prior op.
    op8(8'h80, 8'h01, 1'b1, 1'b0);
    @(negedge clk);
    wait_idle8();
    a8 = 8'h5A; b8 = 8'h3C; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_before_abort", busy8, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_s", s8, 0);
    check("abort_co", co8, 0);
    check("abort_ovf", ovf8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    any = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8) any = 1;
    end
    check("no_done_after_abort", any, 0);
    op8(8'h5A, 8'h3C, 1'b0, 1'b0);

    // start held high: results every WIDTH+2 cycles.
    @(negedge clk);
    wait_idle8();
    a8 = 8'h12; b8 = 8'h34; sub8 = 1'b1; start8 = 1'b1;
    pushes = 0; dones = 0; last_done = -1; n = 0;
    while (dones < 3 && n < 100) begin
      if (!busy8 && !done8 && start8) begin
        if (pushes < 3) begin
          q8.push_back(model(8, 8'h12, 8'h34, 1'b1));
          pushes++;
        end else begin
          start8 = 1'b0;
        end
      end
      @(negedge clk);
      n++;
      if (done8) begin
        if (last_done >= 0) check("spacing8", cycle - last_done, 10);
        last_done = cycle;
        dones++;
      end
    end
    start8 = 1'b0;
    check("hold_results8", dones, 3);

    // Random operations.
    for (int i = 0; i < 40; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    end

    // Exhaustive sweep at WIDTH=4.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int s = 0; s < 2; s++) begin
          op4(4'(a), 4'(b), 1'(s));
        end
      end
    end

    repeat (5) @(negedge clk);
    check("q8_drained", q8.size(), 0);
    check("q4_drained", q4.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
